// File: rtl/clt_gaussian_accum_pkg.sv
// Shared definitions for the CLT Gaussian accumulator: FSM state encodings
// and boolean constants.
package clt_gaussian_accum_pkg;

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_CALC  = 2'd1,
      ST_OUT   = 2'd2
   } state_t;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

endpackage

// File: rtl/clt_gaussian_accum_if.sv
// Stream bundle for the accumulator: uniform word input (u_*) from the URNG
// and Gaussian sample output (g_*) to the noise path.
interface clt_gaussian_accum_if
   import clt_gaussian_accum_pkg::*;
#(
   parameter int OW = 16
) ();

   logic [31:0]   u_data;
   logic          u_valid;
   logic          u_ready;
   logic [OW-1:0] g_data;
   logic          g_valid;
   logic          g_ready;

   modport master (
      output u_data, u_valid, g_ready,
      input  u_ready, g_data, g_valid
   );

   modport slave (
      input  u_data, u_valid, g_ready,
      output u_ready, g_data, g_valid
   );

endinterface

// File: rtl/clt_gaussian_accum_out_stage.sv
// gauss_out_stage: combinational centre (sum - MEAN), arithmetic shift and
// output sizing. Macro GAUSS_SAT_EN selects clamping to the OW-bit signed
// range; without it the sample wraps in two's complement.
module gauss_out_stage
   import clt_gaussian_accum_pkg::*;
#(
   parameter int N_SUM = 12,
   parameter int UW    = 16,
   parameter int OW    = 16,
   parameter int SHIFT = 4,
   parameter int SW    = 20
) (
   input  logic [SW-1:0] i_sum,
   output logic [OW-1:0] o_sample
);

   // One spare bit beyond the larger of centred and output width, so the
   // sign-extended value can always be compared against both limits.
   localparam int EW = (((SW + 1) > OW) ? (SW + 1) : OW) + 1;
   localparam logic [SW:0] MEAN = (SW+1)'(N_SUM) << (UW - 1);

   logic signed [SW:0]   w_centred;
   logic signed [SW:0]   w_scaled;
   logic signed [EW-1:0] w_wide;

   assign w_centred = $signed({1'b0, i_sum}) - $signed(MEAN);
   assign w_scaled  = w_centred >>> SHIFT;
   assign w_wide    = EW'(w_scaled);

`ifdef GAUSS_SAT_EN
   localparam logic signed [EW-1:0] MAXV = {{(EW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [EW-1:0] MINV = {{(EW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   // Clamp out-of-range samples to the nearest representable limit.
   always_comb begin
      o_sample = w_wide[OW-1:0];
      if (w_wide > MAXV) begin
         o_sample = MAXV[OW-1:0];
      end else if (w_wide < MINV) begin
         o_sample = MINV[OW-1:0];
      end
   end
`else
   logic w_unused;

   assign w_unused = ^w_wide[EW-1:OW];
   assign o_sample = w_wide[OW-1:0];
`endif

endmodule

// File: rtl/clt_gaussian_accum.sv
// clt_gaussian_accum: sums N_SUM uniform words (top UW bits each) and emits
// one centred, shifted Gaussian sample per batch. Optional output clamping
// via macro GAUSS_SAT_EN (see gauss_out_stage).
module clt_gaussian_accum
   import clt_gaussian_accum_pkg::*;
#(
   parameter int N_SUM = 12,
   parameter int UW    = 16,
   parameter int OW    = 16,
   parameter int SHIFT = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   clt_gaussian_accum_if.slave  bus
);

   localparam int CW = $clog2(N_SUM + 1);
   localparam int SW = UW + CW;

   state_t        r_state;
   state_t        w_next;
   logic [SW-1:0] r_acc;
   logic [CW-1:0] r_cnt;
   logic [OW-1:0] r_gdata;
   logic          r_gvalid;
   logic [OW-1:0] w_sample;
   logic [UW-1:0] w_u;
   logic          w_uready;
   logic          w_accept;
   logic          w_last;
   logic          w_unused;

   assign w_u      = bus.u_data[31 -: UW];
   assign w_unused = ^bus.u_data;
   assign w_accept = w_uready && bus.u_valid;
   assign w_last   = (r_cnt == CW'(N_SUM - 1));

   assign bus.u_ready = w_uready;
   assign bus.g_data  = r_gdata;
   assign bus.g_valid = r_gvalid;

   gauss_out_stage #(
      .N_SUM (N_SUM),
      .UW    (UW),
      .OW    (OW),
      .SHIFT (SHIFT),
      .SW    (SW)
   ) u_out_stage (
      .i_sum    (r_acc),
      .o_sample (w_sample)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and ready decode; ready depends on state alone.
   always_comb begin
      w_next   = r_state;
      w_uready = FALSE;
      case (r_state)
         ST_ACCUM: begin
            w_uready = TRUE;
            if (w_accept && w_last) begin
               w_next = ST_CALC;
            end
         end
         ST_CALC: begin
            w_next = ST_OUT;
         end
         ST_OUT: begin
            if (r_gvalid && bus.g_ready) begin
               w_next = ST_ACCUM;
            end
         end
         default: begin
            w_next = ST_ACCUM;
         end
      endcase
   end

   // Accumulator, counter and registered output sample.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_acc    <= '0;
         r_cnt    <= '0;
         r_gdata  <= '0;
         r_gvalid <= FALSE;
      end else begin
         case (r_state)
            ST_ACCUM: begin
               if (w_accept) begin
                  r_acc <= r_acc + {{CW{1'b0}}, w_u};
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_CALC: begin
               r_gdata  <= w_sample;
               r_gvalid <= TRUE;
            end
            ST_OUT: begin
               if (r_gvalid && bus.g_ready) begin
                  r_gvalid <= FALSE;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            default: begin
               r_acc <= '0;
               r_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clt_gaussian_accum.sv
// Scoreboard bench for clt_gaussian_accum: two instances (SHIFT=4, SHIFT=2)
// share one randomized input stream; expected samples are computed from the
// accepted words and checked by a monitor on each output handshake.
module tb_clt_gaussian_accum;

   localparam int N = 12;

   logic clk = 1'b0;
   logic resetn = 1'b0;

   always #5 clk = ~clk;

   clt_gaussian_accum_if #(.OW(16)) bus4 ();
   clt_gaussian_accum_if #(.OW(16)) bus2 ();

   assign bus2.u_data  = bus4.u_data;
   assign bus2.u_valid = bus4.u_valid;
   assign bus2.g_ready = bus4.g_ready;

   clt_gaussian_accum #(.N_SUM(12), .UW(16), .OW(16), .SHIFT(4)) u_dut4 (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus4)
   );

   clt_gaussian_accum #(.N_SUM(12), .UW(16), .OW(16), .SHIFT(2)) u_dut2 (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus2)
   );

   int          n_pass  = 0;
   int          n_total = 0;
   int          accepts = 0;
   longint      q4[$];
   longint      q2[$];
   logic [31:0] acc_q[$];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // Reference: exact centred sum, floor division by 2^sh, then clamp or wrap.
   function automatic longint ref_out(input longint sum, input int sh);
      longint c, d, r, q;
      c = sum - longint'(N) * 32768;
      d = longint'(1) << sh;
      r = c % d;
      if (r < 0) r += d;
      q = (c - r) / d;
`ifdef GAUSS_SAT_EN
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
`else
      q = q % 65536;
      if (q < 0) q += 65536;
      if (q >= 32768) q -= 65536;
`endif
      return q;
   endfunction

   always @(posedge clk) begin
      if (resetn && bus4.u_valid && bus4.u_ready) accepts++;
   end

   // Monitor: pop and compare on every output handshake.
   always @(negedge clk) begin
      #1;
      if (resetn && bus4.g_valid && bus4.g_ready) begin
         if (q4.size() == 0) chk("unexpected_out_s4", 1, 0);
         else chk("out_s4", longint'($signed(bus4.g_data)), q4.pop_front());
      end
      if (resetn && bus2.g_valid && bus2.g_ready) begin
         if (q2.size() == 0) chk("unexpected_out_s2", 1, 0);
         else chk("out_s2", longint'($signed(bus2.g_data)), q2.pop_front());
      end
   end

   task automatic send(input logic [31:0] w, input int gap);
      int     k;
      longint s;
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         bus4.u_valid = 1'b0;
      end
      @(negedge clk);
      bus4.u_valid = 1'b1;
      bus4.u_data  = w;
      k = 0;
      while (!bus4.u_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!bus4.u_ready) begin
         chk("u_ready_timeout", longint'(bus4.u_ready), 1);
         return;
      end
      @(posedge clk);
      acc_q.push_back(w);
      if (acc_q.size() == N) begin
         s = 0;
         foreach (acc_q[i]) s += longint'(acc_q[i][31:16]);
         q4.push_back(ref_out(s, 4));
         q2.push_back(ref_out(s, 2));
         acc_q.delete();
      end
   endtask

   task automatic idle();
      @(negedge clk);
      bus4.u_valid = 1'b0;
   endtask

   task automatic wait_gvalid();
      int k = 0;
      while (!bus4.g_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      if (!bus4.g_valid) chk("g_valid_timeout", longint'(bus4.g_valid), 1);
   endtask

   task automatic drain();
      int k = 0;
      while ((q4.size() != 0 || q2.size() != 0) && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("drain_s4", q4.size(), 0);
      chk("drain_s2", q2.size(), 0);
   endtask

   task automatic check_reset_state(input string nm);
      chk({nm, "_g_valid"}, longint'(bus4.g_valid), 0);
      chk({nm, "_g_data"},  longint'(bus4.g_data), 0);
      chk({nm, "_u_ready"}, longint'(bus4.u_ready), 1);
      chk({nm, "_g_data_s2"}, longint'(bus2.g_data), 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus4.u_valid = 1'b0;
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      acc_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint exp_hold;
      int     a0;

      bus4.u_valid = 1'b0;
      bus4.u_data  = '0;
      bus4.g_ready = 1'b1;
      resetn       = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      check_reset_state("reset");

      // Mid-scale words give zero; check 2-cycle latency and 1-cycle pulse.
      for (int unsigned i = 0; i < N; i++) send(32'h8000_0000, 0);
      @(negedge clk);
      bus4.u_valid = 1'b0;
      chk("lat_calc_g_valid", longint'(bus4.g_valid), 0);
      @(negedge clk);
      chk("lat_out_g_valid", longint'(bus4.g_valid), 1);
      chk("mid_g_data", longint'($signed(bus4.g_data)), 0);
      @(negedge clk);
      chk("pulse_end_g_valid", longint'(bus4.g_valid), 0);
      drain();

      // Full-scale words: positive extreme, and wrap/clamp with SHIFT=2.
      for (int unsigned i = 0; i < N; i++) send(32'hFFFF_FFFF, 0);
      idle();
      wait_gvalid();
      chk("max_s4", longint'($signed(bus4.g_data)), 24575);
`ifdef GAUSS_SAT_EN
      chk("max_s2_sat", longint'($signed(bus2.g_data)), 32767);
`else
      chk("max_s2_wrap", longint'($signed(bus2.g_data)), 32765);
`endif
      drain();
      for (int unsigned i = 0; i < N; i++) send(32'h0000_0000, 0);
      idle();
      wait_gvalid();
      chk("min_s4", longint'($signed(bus4.g_data)), -24576);
      drain();

      // Downstream stall with input still offered.
      bus4.g_ready = 1'b0;
      for (int unsigned i = 0; i < N; i++) send($urandom, 0);
      @(negedge clk);
      bus4.u_valid = 1'b1;
      bus4.u_data  = 32'hDEAD_BEEF;
      a0 = accepts;
      wait_gvalid();
      exp_hold = (q4.size() != 0) ? q4[0] : 0;
      for (int unsigned i = 0; i < 10; i++) begin
         chk("stall_g_data", longint'($signed(bus4.g_data)), exp_hold);
         chk("stall_u_ready", longint'(bus4.u_ready), 0);
         @(negedge clk);
      end
      chk("stall_g_valid", longint'(bus4.g_valid), 1);
      chk("stall_no_accept", accepts, a0);
      bus4.u_valid = 1'b0;
      bus4.g_ready = 1'b1;
      drain();

      // Random gaps, three outputs back to back.
      for (int unsigned i = 0; i < 3 * N; i++) send($urandom, $urandom_range(0, 3));
      idle();
      drain();

      // Reset mid-accumulation discards the partial sum.
      for (int unsigned i = 0; i < 7; i++) send($urandom, 0);
      do_reset();
      check_reset_state("reset_mid");
      for (int unsigned i = 0; i < N; i++) send($urandom, $urandom_range(0, 2));
      idle();
      drain();

      // Reset while a sample is being presented.
      bus4.g_ready = 1'b0;
      for (int unsigned i = 0; i < N; i++) send($urandom, 0);
      idle();
      wait_gvalid();
      q4.delete();
      q2.delete();
      do_reset();
      check_reset_state("reset_out");
      bus4.g_ready = 1'b1;

      for (int unsigned i = 0; i < N; i++) send($urandom, 0);
      idle();
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
